// File: rtl/rosc_entropy_collector.sv
// Ring-oscillator entropy collector: two-flop synchronises the oscillator array,
// XOR-folds it to one raw bit per sample interval and packs 32 bits per word.
module rosc_entropy_collector #(
  parameter int unsigned NUM_ROSC      = 32,
  parameter logic [15:0] SAMPLE_CYCLES = 16'h0100,
  parameter logic [15:0] WARMUP_CYCLES = 16'h1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [NUM_ROSC-1:0] rosc_out,
  output logic [31:0]         data,
  output logic                data_valid,
  input  logic                data_ack,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    COLLECT,
    FULL
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_ROSC-1:0] sync1_q, sync2_q;
  logic [15:0]         warm_cnt_q, warm_cnt_d;
  logic [15:0]         presc_q, presc_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [31:0]         shift_q, shift_d;
  logic [31:0]         data_q, data_d;
  logic                valid_q, valid_d;
  logic                sync_bit;
  logic                sample_tick;
  logic [31:0]         shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      warm_cnt_q <= '0;
      presc_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rosc_out;
      sync2_q    <= sync1_q;
      warm_cnt_q <= warm_cnt_d;
      presc_q    <= presc_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    presc_d     = presc_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    sync_bit    = ^sync2_q;
    sample_tick = (presc_q == SAMPLE_CYCLES - 16'd1);
    shifted     = {shift_q[30:0], sync_bit};

    case (state_q)
      IDLE: begin
        if (en) state_d = WARMUP;
      end
      WARMUP: begin
        if (warm_cnt_q == WARMUP_CYCLES - 16'd1) begin
          state_d    = COLLECT;
          warm_cnt_d = '0;
          presc_d    = '0;
        end else begin
          warm_cnt_d = warm_cnt_q + 16'd1;
        end
      end
      COLLECT: begin
        if (sample_tick) begin
          presc_d = '0;
          shift_d = shifted;
          if (bit_cnt_q == 6'd31) begin
            data_d    = shifted;
            valid_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = FULL;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end
      FULL: begin
        if (data_ack && valid_q) begin
          valid_d = 1'b0;
          presc_d = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides ack and word completion; the last word stays readable.
    if (!en) begin
      state_d    = IDLE;
      valid_d    = 1'b0;
      warm_cnt_d = '0;
      presc_d    = '0;
      bit_cnt_d  = '0;
      shift_d    = '0;
    end
  end

  always_comb begin
    busy       = (state_q == WARMUP) || (state_q == COLLECT);
    data       = data_q;
    data_valid = valid_q;
  end

endmodule

// File: tb/tb_rosc_entropy_collector.sv
// Self-checking bench for rosc_entropy_collector with short sample/warm-up periods.
module tb_rosc_entropy_collector;

  localparam int S = 4;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        data_ack;
  logic [31:0] rosc_out;
  logic [31:0] data;
  logic        data_valid;
  logic        busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          mode;       // 0: constant rosc, 1: 32'h1/32'h0, 2: random with parity
    logic [31:0] rosc_const;
    logic [31:0] pat;
    bit          spur;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  rosc_entropy_collector #(
    .NUM_ROSC      (32),
    .SAMPLE_CYCLES (16'd4),
    .WARMUP_CYCLES (16'd8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .rosc_out   (rosc_out),
    .data       (data),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rosc_with_parity(input logic b);
    logic [31:0] r;
    int          idx;
    r = $urandom;
    if ((^r) != b) begin
      idx    = $urandom_range(31, 0);
      r[idx] = ~r[idx];
    end
    return r;
  endfunction

  // Starts at the negedge after the word's base edge; ends at the negedge after the last sample edge.
  task automatic drive_bits(input logic [31:0] pat, input int nbits, input int mode,
                            input logic [31:0] rc, input bit spur);
    for (int k = 0; k < nbits; k++) begin
      case (mode)
        0:       rosc_out = rc;
        1:       rosc_out = pat[31-k] ? 32'h1 : 32'h0;
        default: rosc_out = rosc_with_parity(pat[31-k]);
      endcase
      if (spur && k == 5) data_ack = 1'b1;
      for (int c = 0; c < S; c++) begin
        if (nbits == 32 && k == 31 && c == S - 1)
          check("valid_before_last", {31'b0, data_valid}, 32'h0);
        @(negedge clk);
        data_ack = 1'b0;
      end
    end
  endtask

  task automatic finish_word(input string name);
    logic [31:0] e;
    check({name, "_valid"}, {31'b0, data_valid}, 32'h1);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_queue: got empty scoreboard, want a queued word", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_data"}, data, e);
    end
  endtask

  task automatic run_word(input string name, input int mode, input logic [31:0] rc,
                          input logic [31:0] pat, input bit spur, input logic [31:0] exp);
    exp_q.push_back(exp);
    drive_bits(pat, 32, mode, rc, spur);
    finish_word(name);
  endtask

  task automatic ack_word(input string name);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check({name, "_ack_clr"}, {31'b0, data_valid}, 32'h0);
  endtask

  task automatic warmup(input string name);
    check({name, "_busy_idle"}, {31'b0, busy}, 32'h0);
    en = 1'b1;
    @(negedge clk);
    check({name, "_busy_edge0"}, {31'b0, busy}, 32'h1);
    repeat (W) @(negedge clk);
    check({name, "_busy_collect"}, {31'b0, busy}, 32'h1);
  endtask

  initial begin
    vec_t tbl[6];

    reset    = 1'b1;
    en       = 1'b0;
    data_ack = 1'b0;
    rosc_out = '0;
    #12;
    check("rst_data", data, 32'h0);
    check("rst_valid", {31'b0, data_valid}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    repeat (100) begin
      rosc_out = $urandom;
      @(negedge clk);
    end
    check("idle_data", data, 32'h0);
    check("idle_valid", {31'b0, data_valid}, 32'h0);
    check("idle_busy", {31'b0, busy}, 32'h0);

    tbl[0] = '{0, 32'h0000_0001, 32'h0, 1'b0, 0,   32'hFFFF_FFFF};
    tbl[1] = '{0, 32'h0000_0003, 32'h0, 1'b0, 0,   32'h0000_0000};
    tbl[2] = '{1, 32'h0, 32'hAAAA_AAAA, 1'b0, 0,   32'hAAAA_AAAA};
    tbl[3] = '{2, 32'h0, 32'hC3A5_0F96, 1'b1, 0,   32'hC3A5_0F96};
    tbl[4] = '{2, 32'h0, 32'h1234_5678, 1'b0, 500, 32'h1234_5678};
    tbl[5] = '{1, 32'h0, 32'h8000_0001, 1'b0, 0,   32'h8000_0001};

    warmup("w0");
    for (int i = 0; i < 6; i++) begin
      run_word($sformatf("vec%0d", i), tbl[i].mode, tbl[i].rosc_const, tbl[i].pat,
               tbl[i].spur, tbl[i].exp);
      if (tbl[i].hold > 0) begin
        for (int c = 0; c < tbl[i].hold; c++) begin
          rosc_out = $urandom;
          @(negedge clk);
        end
        check($sformatf("vec%0d_hold_valid", i), {31'b0, data_valid}, 32'h1);
        check($sformatf("vec%0d_hold_data", i), data, tbl[i].exp);
      end
      ack_word($sformatf("vec%0d", i));
    end

    // Disable on the same edge as an ack in FULL.
    run_word("full", 2, 32'h0, 32'h5A5A_F00D, 1'b0, 32'h5A5A_F00D);
    en       = 1'b0;
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("dis_valid", {31'b0, data_valid}, 32'h0);
    check("dis_busy", {31'b0, busy}, 32'h0);
    check("dis_data", data, 32'h5A5A_F00D);
    repeat (5) @(negedge clk);
    check("dis_data_hold", data, 32'h5A5A_F00D);

    warmup("w1");
    run_word("reen", 2, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    ack_word("reen");

    // Disable after 20 samples; the next word must hold only new samples.
    drive_bits(32'hFFFF_FFFF, 20, 2, 32'h0, 1'b0);
    en = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", {31'b0, busy}, 32'h0);
    check("mid_valid", {31'b0, data_valid}, 32'h0);
    warmup("w2");
    run_word("mid", 2, 32'h0, 32'h0F0F_3C3C, 1'b0, 32'h0F0F_3C3C);
    ack_word("mid");

    // Asynchronous reset mid-word, away from any clock edge.
    drive_bits(32'hFFFF_0000, 10, 2, 32'h0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_data", data, 32'h0);
    check("arst_valid", {31'b0, data_valid}, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    warmup("w3");
    run_word("post_rst", 2, 32'h0, 32'h6B1D_2E47, 1'b0, 32'h6B1D_2E47);
    ack_word("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rosc_entropy_collector.md
# rosc_entropy_collector

Digitising stage directly downstream of the TRNG ring-oscillator array. It takes the free-running oscillator outputs, synchronises them into the system clock domain, and XOR-folds them into one raw bit per sample interval. It packs 32 consecutive bits into a word and offers the word to the TRNG core through a valid/ack handshake. It performs no whitening or health testing; those belong downstream.

## Interface
- NUM_ROSC, 32: number of ring-oscillator outputs sampled (1..64).
- SAMPLE_CYCLES, 16'h0100: clock cycles per raw bit sample (2..65535).
- WARMUP_CYCLES, 16'h1000: cycles discarded after enable before collection starts (1..65535).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset; all state cleared immediately.
- en  in  1  collector enable; level-sensitive.
- rosc_out  in  NUM_ROSC  raw oscillator outputs, asynchronous to clk.
- data  out  32  collected entropy word.
- data_valid  out  1  data holds a complete word not yet acknowledged.
- data_ack  in  1  consumer has taken data (single-cycle pulse).
- busy  out  1  high in WARMUP and COLLECT.

## Operation
- Sync: each rosc_out bit passes through two flops (the sync stage is also reset); sync_bit = XOR-reduce of the second-stage vector.
- FSM states: IDLE, WARMUP, COLLECT, FULL.
  - IDLE: counters zero. en=1 -> WARMUP.
  - WARMUP: cycle counter increments each cycle. At count WARMUP_CYCLES-1 -> COLLECT, with counter and prescaler cleared.
  - COLLECT: prescaler counts 0..SAMPLE_CYCLES-1 and wraps. On the wrap cycle, shift_reg <= {shift_reg[30:0], sync_bit} and bit_cnt increments. When the 32nd bit shifts in: data <= shifted value, data_valid <= 1, bit_cnt <= 0, -> FULL.
  - FULL: prescaler and shift register frozen. data_ack=1 -> data_valid <= 0, prescaler <= 0, -> COLLECT. No warm-up is repeated.
- en=0 in any state -> IDLE next cycle. data_valid clears, bit_cnt, prescaler and shift_reg clear, data retains its last value. en=0 takes priority over a simultaneous data_ack or word completion.
- data_ack while data_valid=0 is ignored.
- Bit order: the first sampled bit of a word ends in data[31], the last in data[0].
- Widths: prescaler and warm-up counter 16 bits, bit_cnt 5 bits with a separate completion flag, or 6 bits. No counter may wrap silently.

## Timing
- Reset values: data=32'h0, data_valid=0, busy=0, state IDLE, all counters 0.
- Define cycle 0 as the first rising edge at which en is sampled 1 in IDLE. busy=1 from after edge 0.
- COLLECT is entered after edge WARMUP_CYCLES.
- First sample is taken at edge WARMUP_CYCLES+SAMPLE_CYCLES. The k-th sample is taken at edge WARMUP_CYCLES+k*SAMPLE_CYCLES.
- data_valid rises after edge WARMUP_CYCLES+32*SAMPLE_CYCLES, the same edge that captures the 32nd bit.
- data_ack sampled at edge t: data_valid low after t. The next word's first sample is at edge t+SAMPLE_CYCLES; the next data_valid comes after edge t+32*SAMPLE_CYCLES.
- Synchroniser latency is 2 cycles: a rosc_out change must be stable 2 cycles before the sampling edge to be seen.
- reset asserted mid-word: outputs return to reset values without waiting for a clock edge. After release, a full warm-up is required.

## Test plan
- Reset/idle: assert reset with en=1 mid-COLLECT -> data=0, data_valid=0, busy=0 immediately. en=0 for 100 cycles -> outputs unchanged.
- Constant entropy: SAMPLE_CYCLES=4, WARMUP_CYCLES=8, rosc_out=32'h1 (XOR=1), en=1 -> data_valid rises after edge 136, data=32'hFFFFFFFF. With rosc_out=32'h3 -> data=32'h00000000.
- Bit order: same parameters, toggle rosc_out between 32'h1 and 32'h0 two cycles before each sample edge, starting with 1 -> data=32'hAAAAAAAA.
- Backpressure: leave data_valid high, hold data_ack=0 for 500 cycles and change rosc_out throughout -> data unchanged and no samples taken. Pulse data_ack at edge t -> data_valid low after t, next data_valid after t+128.
- Spurious/simultaneous: data_ack pulsed in COLLECT -> no effect. en=0 on the same edge as data_ack in FULL -> IDLE, data_valid=0, data keeps its value. Re-enable -> first valid after a full 8+128 cycles.
- Disable mid-word: en=0 after 20 samples, then en=1 -> warm-up repeats, and the next word contains only new samples (verify against the driven pattern).
